control_pipeline: RTL and testbench

Pipeline sequencing controller for the 5-stage filter processor (F, Reg, Exe, Mem, WB). It generates the per-stage enable and flush controls. It resolves the hazards that the forwarding unit cannot cover:
- load-use bubbles
- taken-branch flush
- multi-cycle data-memory wait states
- an orderly halt/drain sequence

It sits beside the forwarding unit and drives the pipeline register banks and the PC.

---
 rtl/control_pipeline_pkg.sv | 32 +++
 rtl/control_pipeline_if.sv | 42 ++++
 rtl/control_pipeline_wait_timer.sv | 31 +++
 rtl/control_pipeline.sv | 144 ++++++++++++++
 tb/tb_control_pipeline.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/control_pipeline_pkg.sv
// Shared types and defaults for the 5-stage pipeline sequencing controller.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALT
  } state_e;

  localparam int unsigned DEF_MEM_TIMEOUT  = 16;
  localparam int unsigned DEF_DRAIN_CYCLES = 4;
  localparam int unsigned DEF_CNT_W        = 16;

  typedef struct packed {
    logic en_pc;
    logic en_f_reg;
    logic en_reg_exe;
    logic en_exe_mem;
    logic en_mem_wb;
    logic flush_f_reg;
    logic flush_reg_exe;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam ctrl_t CTRL_FREEZE = '0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// Hazard inputs, memory handshake, halt control and per-stage control outputs.
interface control_pipeline_if #(
  parameter int unsigned CNT_W = ctrl_pkg::DEF_CNT_W
);
  logic [3:0]       Ra_F_Reg;
  logic             RE_A_F_Reg;
  logic [3:0]       Rb_F_Reg;
  logic             RE_B_F_Reg;
  logic [3:0]       Robj_Reg_Exe;
  logic             WE_Reg_Exe;
  logic             mem_RE_Reg_Exe;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             halt_req;
  logic             resume;
  logic             en_PC;
  logic             en_F_Reg;
  logic             en_Reg_Exe;
  logic             en_Exe_Mem;
  logic             en_Mem_WB;
  logic             flush_F_Reg;
  logic             flush_Reg_Exe;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Ra_F_Reg, RE_A_F_Reg, Rb_F_Reg, RE_B_F_Reg, Robj_Reg_Exe, WE_Reg_Exe,
           mem_RE_Reg_Exe, branch_taken, mem_req, mem_ack, halt_req, resume,
    input  en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB,
           flush_F_Reg, flush_Reg_Exe, halted, mem_err, stall_cnt
  );

  modport slave (
    input  Ra_F_Reg, RE_A_F_Reg, Rb_F_Reg, RE_B_F_Reg, Robj_Reg_Exe, WE_Reg_Exe,
           mem_RE_Reg_Exe, branch_taken, mem_req, mem_ack, halt_req, resume,
    output en_PC, en_F_Reg, en_Reg_Exe, en_Exe_Mem, en_Mem_WB,
           flush_F_Reg, flush_Reg_Exe, halted, mem_err, stall_cnt
  );

endinterface

// File: rtl/control_pipeline_wait_timer.sv
// Loadable up/down counter with a terminal-count flag; used for memory wait and drain.
module wait_timer #(
  parameter int unsigned W    = 5,
  parameter int unsigned TERM = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
    else if (dec_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == W'(TERM));

endmodule

// File: rtl/control_pipeline.sv
// Pipeline sequencing controller: load-use bubbles, branch flush, memory wait states, halt/drain.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  control_pipeline_if.slave bus
);

  localparam int unsigned TW =
    cnt_width((MEM_TIMEOUT > DRAIN_CYCLES) ? MEM_TIMEOUT : DRAIN_CYCLES);

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use, mem_stall, mem_done;
  logic             mw_load, mw_inc, mw_term;
  logic             dr_load, dr_dec, dr_term;

  assign load_use  = bus.mem_RE_Reg_Exe & bus.WE_Reg_Exe &
                     ((bus.RE_A_F_Reg & (bus.Ra_F_Reg == bus.Robj_Reg_Exe)) |
                      (bus.RE_B_F_Reg & (bus.Rb_F_Reg == bus.Robj_Reg_Exe)));
  assign mem_stall = bus.mem_req & ~bus.mem_ack;
  assign mem_done  = bus.mem_req & bus.mem_ack;

  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_RUN;
    mem_err_d = mem_err_q;
    mw_load   = 1'b0;
    mw_inc    = 1'b0;
    dr_load   = 1'b0;
    dr_dec    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          mw_load = 1'b1;
        end else if (bus.branch_taken) begin
          // the load-use dependent is squashed by the flush, so no bubble is needed
          ctrl.flush_f_reg   = 1'b1;
          ctrl.flush_reg_exe = 1'b1;
        end else if (load_use) begin
          ctrl.en_pc         = 1'b0;
          ctrl.en_f_reg      = 1'b0;
          ctrl.flush_reg_exe = 1'b1;
        end else if (bus.halt_req) begin
          state_d = DRAIN;
          dr_load = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          state_d = bus.halt_req ? DRAIN : RUN;
          dr_load = bus.halt_req;
        end else begin
          ctrl = CTRL_FREEZE;
          if (mw_term) begin
            mem_err_d = 1'b1;
            state_d   = HALT;
          end else begin
            mw_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl.en_pc         = 1'b0;
          ctrl.flush_f_reg   = 1'b1;
          ctrl.flush_reg_exe = bus.branch_taken;
          dr_dec             = 1'b1;
          if (dr_term) state_d = HALT;
        end
      end
      HALT: begin
        ctrl = CTRL_FREEZE;
        if (bus.resume) begin
          state_d   = RUN;
          mem_err_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.en_pc && (state_q != HALT) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  wait_timer #(.W(TW), .TERM(MEM_TIMEOUT)) u_mem_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (mw_load),
    .load_val_i (TW'(1)),
    .inc_i      (mw_inc),
    .dec_i      (1'b0),
    .term_o     (mw_term)
  );

  wait_timer #(.W(TW), .TERM(1)) u_drain_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dr_load),
    .load_val_i (TW'(DRAIN_CYCLES)),
    .inc_i      (1'b0),
    .dec_i      (dr_dec),
    .term_o     (dr_term)
  );

  // banks see NOPs and no loads for as long as reset is held
  assign bus.en_PC         = rst_n & ctrl.en_pc;
  assign bus.en_F_Reg      = rst_n & ctrl.en_f_reg;
  assign bus.en_Reg_Exe    = rst_n & ctrl.en_reg_exe;
  assign bus.en_Exe_Mem    = rst_n & ctrl.en_exe_mem;
  assign bus.en_Mem_WB     = rst_n & ctrl.en_mem_wb;
  assign bus.flush_F_Reg   = ~rst_n | ctrl.flush_f_reg;
  assign bus.flush_Reg_Exe = ~rst_n | ctrl.flush_reg_exe;
  assign bus.halted        = (state_q == HALT);
  assign bus.mem_err       = mem_err_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed hazard scenarios then randomized traffic vs. a reference model.
module tb_control_pipeline;

  localparam int MEM_TO    = 16;
  localparam int DRAIN     = 4;
  localparam int CW        = 8;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_pipeline_if #(.CNT_W(CW)) bus ();

  control_pipeline #(
    .MEM_TIMEOUT  (MEM_TO),
    .DRAIN_CYCLES (DRAIN),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model: remaining wait/drain work and sticky flags
  int m_wait   = 0;
  int m_drain  = 0;
  int m_stalls = 0;
  bit m_halt   = 1'b0;
  bit m_err    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {bus.en_PC, bus.en_F_Reg, bus.en_Reg_Exe, bus.en_Exe_Mem, bus.en_Mem_WB,
            bus.flush_F_Reg, bus.flush_Reg_Exe};
  endfunction

  task automatic set_idle();
    bus.Ra_F_Reg       = 4'd0;
    bus.RE_A_F_Reg     = 1'b0;
    bus.Rb_F_Reg       = 4'd0;
    bus.RE_B_F_Reg     = 1'b0;
    bus.Robj_Reg_Exe   = 4'd0;
    bus.WE_Reg_Exe     = 1'b0;
    bus.mem_RE_Reg_Exe = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.mem_req        = 1'b0;
    bus.mem_ack        = 1'b0;
    bus.halt_req       = 1'b0;
    bus.resume         = 1'b0;
  endtask

  task automatic set_load_use();
    bus.Robj_Reg_Exe   = 4'd1;
    bus.WE_Reg_Exe     = 1'b1;
    bus.mem_RE_Reg_Exe = 1'b1;
    bus.Ra_F_Reg       = 4'd1;
    bus.RE_A_F_Reg     = 1'b1;
  endtask

  // called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic cycle();
    logic [6:0] exp;
    bit lu, ms, ack, was_halted;
    #1;
    check_eq("halted", 32'(bus.halted), 32'(m_halt));
    check_eq("mem_err", 32'(bus.mem_err), 32'(m_err));
    check_eq("stall_cnt", 32'(bus.stall_cnt), 32'(m_stalls));
    lu = bus.mem_RE_Reg_Exe && bus.WE_Reg_Exe &&
         ((bus.RE_A_F_Reg && bus.Ra_F_Reg == bus.Robj_Reg_Exe) ||
          (bus.RE_B_F_Reg && bus.Rb_F_Reg == bus.Robj_Reg_Exe));
    ms  = bus.mem_req && !bus.mem_ack;
    ack = bus.mem_req && bus.mem_ack;
    was_halted = m_halt;
    exp = 7'b1111100;
    if (m_halt) begin
      exp = '0;
      if (bus.resume) begin m_halt = 1'b0; m_err = 1'b0; end
    end else if (m_wait != 0) begin
      if (ack) begin
        m_wait = 0;
        if (bus.halt_req) m_drain = DRAIN;
      end else begin
        exp = '0;
        if (m_wait == MEM_TO) begin m_wait = 0; m_err = 1'b1; m_halt = 1'b1; end
        else m_wait++;
      end
    end else if (m_drain != 0) begin
      if (ms) exp = '0;
      else begin
        exp = {1'b0, 4'b1111, 1'b1, bus.branch_taken};
        m_drain--;
        if (m_drain == 0) m_halt = 1'b1;
      end
    end else if (ms) begin
      exp = '0;
      m_wait = 1;
    end else if (bus.branch_taken) exp = 7'b1111111;
    else if (lu)                   exp = 7'b0011101;
    else if (bus.halt_req)         m_drain = DRAIN;
    check_eq("ctrl", 32'(ctrl_vec()), 32'(exp));
    if (!was_halted && !exp[6] && m_stalls < STALL_MAX) m_stalls++;
    @(negedge clk);
  endtask

  // asserts reset mid low phase, checks forced outputs, releases at the next falling edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'(ctrl_vec()), 32'(7'b0000011));
    check_eq("rst_halted", 32'(bus.halted), 32'd0);
    check_eq("rst_mem_err", 32'(bus.mem_err), 32'd0);
    check_eq("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    m_wait = 0; m_drain = 0; m_stalls = 0; m_halt = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    do_reset();

    // load-use gives one bubble
    set_load_use(); cycle();
    set_idle(); cycle();
    #1 check_eq("lu_stall_total", 32'(bus.stall_cnt), 32'd1);

    // taken branch squashes the dependent: flushes, no stall
    set_load_use(); bus.branch_taken = 1'b1; cycle();
    set_idle(); cycle();
    #1 check_eq("br_lu_stall_total", 32'(bus.stall_cnt), 32'd1);

    // mem_ack without mem_req is ignored
    bus.mem_ack = 1'b1; cycle();

    // 3-cycle memory wait
    set_idle(); bus.mem_req = 1'b1;
    repeat (3) cycle();
    bus.mem_ack = 1'b1; cycle();
    set_idle(); cycle();
    #1 check_eq("memwait_stall_total", 32'(bus.stall_cnt), 32'd4);

    // timeout: one RUN stall cycle then MEM_TO cycles in MEM_WAIT
    bus.mem_req = 1'b1;
    repeat (MEM_TO + 1) cycle();
    #1 check_eq("timeout_halted", 32'(bus.halted), 32'd1);
    check_eq("timeout_err", 32'(bus.mem_err), 32'd1);
    set_idle();
    repeat (3) cycle();
    bus.resume = 1'b1; cycle();
    bus.resume = 1'b0; cycle();
    #1 check_eq("resume_err_clear", 32'(bus.mem_err), 32'd0);
    check_eq("resume_stall_total", 32'(bus.stall_cnt), 32'(4 + MEM_TO + 1));

    // halt with a 2-cycle memory stall and a branch inside DRAIN
    bus.halt_req = 1'b1; cycle();
    bus.halt_req = 1'b0; cycle();
    bus.mem_req = 1'b1; repeat (2) cycle();
    bus.mem_req = 1'b0; bus.branch_taken = 1'b1; cycle();
    bus.branch_taken = 1'b0; repeat (2) cycle();
    #1 check_eq("drain_halted", 32'(bus.halted), 32'd1);
    cycle();
    bus.resume = 1'b1; bus.halt_req = 1'b1; cycle();
    set_idle(); cycle();

    // reset in the middle of MEM_WAIT and of DRAIN
    bus.mem_req = 1'b1; repeat (3) cycle();
    do_reset();
    set_idle(); cycle();
    bus.halt_req = 1'b1; cycle();
    bus.halt_req = 1'b0; cycle();
    do_reset();
    cycle();

    for (int i = 0; i < 4000; i++) begin
      bus.Ra_F_Reg       = 4'($urandom_range(0, 3));
      bus.Rb_F_Reg       = 4'($urandom_range(0, 3));
      bus.Robj_Reg_Exe   = 4'($urandom_range(0, 3));
      bus.RE_A_F_Reg     = 1'($urandom_range(0, 1));
      bus.RE_B_F_Reg     = 1'($urandom_range(0, 1));
      bus.WE_Reg_Exe     = ($urandom_range(0, 3) != 0);
      bus.mem_RE_Reg_Exe = ($urandom_range(0, 2) == 0);
      bus.branch_taken   = ($urandom_range(0, 5) == 0);
      bus.mem_req        = (m_wait != 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      bus.mem_ack        = ($urandom_range(0, 5) == 0);
      bus.halt_req       = ($urandom_range(0, 19) == 0);
      bus.resume         = ($urandom_range(0, 7) == 0);
      cycle();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
